// File: rtl/r2_seg7_display.sv
// r2_seg7_display
//   Shows the 13-bit R2 debug value of pipe_MIPS32 on a 4-digit, common-anode,
//   time-multiplexed 7-segment display.
//   - Binary to BCD via a sequential double-dabble engine (13 shift steps).
//   - Digit scanner with a REFRESH_DIV-cycle prescaler per digit.
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When defined, digits 3..1 are blanked while they and every higher digit
//     are zero. Digit 0 is always shown.
module r2_seg7_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] value_in,
   output logic [15:0] bcd_out,
   output logic        busy,
   output logic [3:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n
);

   // Prescaler width; a divide of 1 still needs a one-bit counter.
   localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   genvar gi;

   // ------------------------------------------------------------------
   // Conversion engine state
   // ------------------------------------------------------------------
   state_t      state_reg;
   logic [12:0] last_q;        // value whose BCD is currently in bcd_out
   logic [12:0] capture_reg;   // value being converted
   logic [28:0] shift_reg;     // {BCD[15:0], binary[12:0]}
   logic [3:0]  cnt;           // shifts already performed
   logic [15:0] bcd_adj;       // BCD part after the add-3 correction
   logic [28:0] shift_next;

   // Add-3 correction on every BCD nibble that is 5 or more, so the
   // following left shift carries correctly into the next decimal digit.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] =
            (shift_reg[13 + gi*4 +: 4] >= 4'd5) ? (shift_reg[13 + gi*4 +: 4] + 4'd3)
                                                : shift_reg[13 + gi*4 +: 4];
      end
   endgenerate

   // Corrected BCD and untouched binary part shifted left by one as a whole.
   assign shift_next = {bcd_adj[14:0], shift_reg[12:0], 1'b0};

   // Conversion FSM: detect a new value, run 13 double-dabble steps, publish.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         last_q      <= '0;
         capture_reg <= '0;
         shift_reg   <= '0;
         cnt         <= '0;
         bcd_out     <= '0;
         busy        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               // Input is only looked at here, so changes during a
               // conversion are picked up once it has finished.
               if (value_in != last_q) begin
                  capture_reg <= value_in;
                  shift_reg   <= {16'h0000, value_in};
                  cnt         <= 4'd0;
                  busy        <= 1'b1;
                  state_reg   <= SHIFT;
               end
            end
            SHIFT: begin
               shift_reg <= shift_next;
               cnt       <= cnt + 4'd1;
               if (cnt == 4'd12) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               bcd_out   <= shift_reg[28:13];
               last_q    <= capture_reg;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Digit scanner
   // ------------------------------------------------------------------
   logic [PRE_W-1:0] prescale_reg;
   logic [1:0]       digit_idx;
   logic [3:0]       digit_val;
   logic             digit_blank;
   logic [3:0]       an_next;
   logic [6:0]       seg_next;

   // Segment patterns {g,f,e,d,c,b,a}, active-low; non-decimal codes go dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Prescaler: advance to the next digit every REFRESH_DIV cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale_reg <= '0;
         digit_idx    <= 2'd0;
      end else if (prescale_reg == PRE_LAST) begin
         prescale_reg <= '0;
         digit_idx    <= digit_idx + 2'd1;
      end else begin
         prescale_reg <= prescale_reg + PRE_W'(1);
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // lz[i] is set when digit i and every digit above it are zero.
   logic [3:0] lz;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lz
         assign lz[gi] = ~|bcd_out[15:gi*4];
      end
   endgenerate
   assign digit_blank = (digit_idx != 2'd0) && lz[digit_idx];
`else
   assign digit_blank = 1'b0;
`endif

   // Select the active digit and form its anode and segment patterns.
   always_comb begin
      digit_val = bcd_out[{digit_idx, 2'b00} +: 4];
      an_next   = ~(4'b0001 << digit_idx);
      seg_next  = digit_blank ? 7'b1111111 : seg_decode(digit_val);
   end

   // Register the display drive every cycle so a new bcd_out shows up
   // without waiting for the digit boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_n  <= 4'b1110;
         seg_n <= 7'b1000000;
      end else begin
         an_n  <= an_next;
         seg_n <= seg_next;
      end
   end

   assign dp_n = 1'b1;

endmodule

// File: tb/tb_r2_seg7_display.sv
// tb_r2_seg7_display
//   Self-checking bench for r2_seg7_display with REFRESH_DIV = 4.
//   Expected BCD results are queued when a value is driven and popped when
//   the conversion finishes (busy falls).
`timescale 1ns/1ps
module tb_r2_seg7_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] value_in = '0;
   logic [15:0] bcd_out;
   logic        busy;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] exp_q[$];

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LEAD_ZERO_SEG = 7'b1111111;
`else
   localparam logic [6:0] LEAD_ZERO_SEG = 7'b1000000;
`endif

   always #5 clk = ~clk;

   r2_seg7_display #(.REFRESH_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .value_in (value_in),
      .bcd_out  (bcd_out),
      .busy     (busy),
      .an_n     (an_n),
      .seg_n    (seg_n),
      .dp_n     (dp_n)
   );

   // Waits (bounded) for busy to rise and fall. Reports cycles until busy
   // was first seen, number of samples with busy high, and bcd_out on the
   // last busy sample.
   task automatic wait_done(output int start_cyc, output int busy_cyc,
                            output logic [15:0] pre_bcd, output bit timeout);
      start_cyc = 0;
      busy_cyc  = 0;
      pre_bcd   = '0;
      timeout   = 1'b0;
      do begin
         @(negedge clk);
         start_cyc++;
      end while (!busy && start_cyc < 10);
      if (!busy) begin
         timeout = 1'b1;
         return;
      end
      busy_cyc = 1;
      pre_bcd  = bcd_out;
      forever begin
         @(negedge clk);
         if (!busy) break;
         busy_cyc++;
         pre_bcd = bcd_out;
         if (busy_cyc > 40) begin
            timeout = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      logic seen_busy;
      rst      = 1'b1;
      value_in = '0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bcd_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_bcd got %h want 0000", bcd_out); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests_run++;
      if (an_n !== 4'b1110) begin tests_failed++; $display("FAIL reset_an got %b want 1110", an_n); end
      tests_run++;
      if (seg_n !== 7'b1000000) begin tests_failed++; $display("FAIL reset_seg got %b want 1000000", seg_n); end
      tests_run++;
      if (dp_n !== 1'b1) begin tests_failed++; $display("FAIL reset_dp got %b want 1", dp_n); end
      rst = 1'b0;
      seen_busy = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
      end
      tests_run++;
      if (seen_busy !== 1'b0) begin tests_failed++; $display("FAIL zero_no_conv busy seen %b want 0", seen_busy); end
      $display("[TB] test_reset done bcd=%h", bcd_out);
   endtask

   task automatic test_latency;
      int st, bc;
      logic [15:0] pre, exp;
      bit to;
      value_in = 13'd1234;
      exp_q.push_back(16'h1234);
      wait_done(st, bc, pre, to);
      exp = exp_q.pop_front();
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL latency_timeout got timeout want busy pulse"); end
      tests_run++;
      if (st != 1) begin tests_failed++; $display("FAIL latency_start got %0d want 1", st); end
      tests_run++;
      if (bc != 14) begin tests_failed++; $display("FAIL latency_busy_cycles got %0d want 14", bc); end
      tests_run++;
      if (pre !== 16'h0000) begin tests_failed++; $display("FAIL latency_early_update got %h want 0000", pre); end
      tests_run++;
      if (bcd_out !== exp) begin tests_failed++; $display("FAIL latency_bcd got %h want %h", bcd_out, exp); end
      $display("[TB] latency value=1234 busy_cycles=%0d bcd=%h", bc, bcd_out);
   endtask

   task automatic test_back_to_back;
      logic [12:0] vals [3];
      logic [15:0] exps [3];
      int st, bc;
      logic [15:0] pre, exp;
      bit to;
      vals[0] = 13'd8191; exps[0] = 16'h8191;
      vals[1] = 13'd0;    exps[1] = 16'h0000;
      vals[2] = 13'd9;    exps[2] = 16'h0009;
      for (int i = 0; i < 3; i++) begin
         value_in = vals[i];
         exp_q.push_back(exps[i]);
         wait_done(st, bc, pre, to);
         exp = exp_q.pop_front();
         tests_run++;
         if (to || st != 1) begin tests_failed++; $display("FAIL b2b_start[%0d] got %0d (timeout %0d) want 1", i, st, to); end
         tests_run++;
         if (bc != 14) begin tests_failed++; $display("FAIL b2b_busy[%0d] got %0d want 14", i, bc); end
         tests_run++;
         if (bcd_out !== exp) begin tests_failed++; $display("FAIL b2b_bcd[%0d] got %h want %h", i, bcd_out, exp); end
         $display("[TB] back_to_back value=%0d bcd=%h", vals[i], bcd_out);
      end
   endtask

   task automatic test_change_during;
      int st, bc, n;
      logic [15:0] pre, exp;
      bit to;
      value_in = 13'd100;
      exp_q.push_back(16'h0100);
      exp_q.push_back(16'h0200);
      repeat (5) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL change_busy_mid got %b want 1", busy); end
      value_in = 13'd200;
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      exp = exp_q.pop_front();
      tests_run++;
      if (busy || bcd_out !== exp) begin tests_failed++; $display("FAIL change_first got %h busy %b want %h", bcd_out, busy, exp); end
      $display("[TB] change_during first bcd=%h", bcd_out);
      wait_done(st, bc, pre, to);
      exp = exp_q.pop_front();
      tests_run++;
      if (to || st != 1 || bc != 14) begin tests_failed++; $display("FAIL change_second_timing got start %0d busy %0d want 1/14", st, bc); end
      tests_run++;
      if (bcd_out !== exp) begin tests_failed++; $display("FAIL change_second got %h want %h", bcd_out, exp); end
      $display("[TB] change_during second bcd=%h", bcd_out);
   endtask

   task automatic test_scan(input logic [12:0] v, input logic [15:0] vbcd,
                            input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
      int st, bc, n;
      logic [15:0] pre, exp;
      logic [6:0] es [4];
      logic [3:0] ea, prev_an;
      bit to, found;
      es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
      value_in = v;
      exp_q.push_back(vbcd);
      wait_done(st, bc, pre, to);
      exp = exp_q.pop_front();
      tests_run++;
      if (to || bcd_out !== exp) begin tests_failed++; $display("FAIL scan_bcd got %h want %h", bcd_out, exp); end
      // Align to the first cycle of digit 0.
      prev_an = an_n;
      found   = 1'b0;
      n       = 0;
      while (!found && n < 40) begin
         @(negedge clk);
         n++;
         if (an_n === 4'b1110 && prev_an !== 4'b1110) found = 1'b1;
         prev_an = an_n;
      end
      tests_run++;
      if (!found) begin tests_failed++; $display("FAIL scan_sync got an_n %b want 1110 edge", an_n); end
      for (int d = 0; d < 4; d++) begin
         ea    = 4'b1111;
         ea[d] = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (d != 0 || k != 0) @(negedge clk);
            tests_run++;
            if (an_n !== ea || seg_n !== es[d]) begin
               tests_failed++;
               $display("FAIL scan_digit[%0d.%0d] got an %b seg %b want an %b seg %b", d, k, an_n, seg_n, ea, es[d]);
            end
         end
         $display("[TB] scan value=%0d digit=%0d an_n=%b seg_n=%b", v, d, an_n, seg_n);
      end
   endtask

   task automatic test_reset_mid;
      int st, bc;
      logic [15:0] pre, exp;
      bit to;
      value_in = 13'd4321;
      exp_q.push_back(16'h4321);
      repeat (6) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
      rst = 1'b1;
      #1;
      tests_run++;
      if (busy !== 1'b0 || bcd_out !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_abort got busy %b bcd %h want 0 0000", busy, bcd_out); end
      tests_run++;
      if (an_n !== 4'b1110 || seg_n !== 7'b1000000 || dp_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_display got an %b seg %b dp %b want 1110 1000000 1", an_n, seg_n, dp_n);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(16'h4321);
      wait_done(st, bc, pre, to);
      exp = exp_q.pop_front();
      tests_run++;
      if (to || st != 1 || bc != 14) begin tests_failed++; $display("FAIL rstmid_timing got start %0d busy %0d want 1/14", st, bc); end
      tests_run++;
      if (bcd_out !== exp) begin tests_failed++; $display("FAIL rstmid_bcd got %h want %h", bcd_out, exp); end
      $display("[TB] reset_mid restart bcd=%h", bcd_out);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_change_during();
      test_scan(13'd1234, 16'h1234, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
      test_scan(13'd7, 16'h0007, 7'b1111000, LEAD_ZERO_SEG, LEAD_ZERO_SEG, LEAD_ZERO_SEG);
      test_reset_mid();
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
